// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the parametrised sequence detector.
// The reset defaults reproduce the classic 11011 non-overlapping detector.
package seq_det_pkg;

    // Width of a length field able to hold 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam logic [7:0] DEF_PATTERN = 8'b0001_1011;
    localparam int         DEF_LENGTH  = 5;
    localparam bit         DEF_OVERLAP = 1'b0;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Reusable by other FSM blocks that need an event tally.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    // Count events, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial bit-sequence detector with a registered
// match pulse, overlapping/non-overlapping modes and a saturating match count.
//
// Handshake: a data bit on `in` is consumed only on a rising clk edge where
// en=1 (and no legal cfg_load is taking priority). With en=0 nothing moves
// except that the match pulse drops, so gaps in en are transparent.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 16,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(DEF_PATTERN),
    parameter int                 DEF_LEN = DEF_LENGTH,
    parameter bit                 DEF_OVL = DEF_OVERLAP
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             in,
    input  logic                             cfg_load,
    input  logic [MAX_LEN-1:0]               pat,
    input  logic [$clog2(MAX_LEN+1)-1:0]     len,
    input  logic                             overlap,
    output logic                             out,
    output logic [CNT_W-1:0]                 match_cnt,
    output logic                             cnt_sat,
    output logic                             cfg_err
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic [MAX_LEN-1:0] hist;   // newest bit at LSB
    logic [LEN_W-1:0]   fill;   // bits seen since last restart, saturates at MAX_LEN

    logic [MAX_LEN-1:0] nxt;
    logic [MAX_LEN-1:0] mask;
    logic               len_ok;
    logic               load_ok;
    logic               fill_ok;
    logic               match;

    // Window including the incoming bit, and the legality/compare terms.
    always_comb begin
        nxt     = {hist[MAX_LEN-2:0], in};
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(cfg_len));
        end
        len_ok  = (len != '0) && (int'(len) <= MAX_LEN);
        load_ok = cfg_load && len_ok;
        fill_ok = (int'(fill) + 1) >= int'(cfg_len);
        // Bits above cfg_len are masked out and never affect the compare.
        match   = en && !load_ok && fill_ok && (((nxt ^ cfg_pat) & mask) == '0);
    end

    // Configuration capture, history shift, fill tracking, match pulse and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pat <= DEF_PAT;
            cfg_len <= LEN_W'(DEF_LEN);
            cfg_ovl <= DEF_OVL;
            hist    <= '0;
            fill    <= '0;
            out     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !len_ok;
            if (load_ok) begin
                // New configuration: restart detection, drop the bit on in.
                cfg_pat <= pat;
                cfg_len <= len;
                cfg_ovl <= overlap;
                hist    <= '0;
                fill    <= '0;
                out     <= 1'b0;
            end else if (en) begin
                hist <= nxt;
                out  <= match;
                if (match && !cfg_ovl) begin
                    // Non-overlapping: next match needs cfg_len fresh bits.
                    fill <= '0;
                end else if (int'(fill) != MAX_LEN) begin
                    fill <= fill + LEN_W'(1);
                end
            end else begin
                out <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (load_ok),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: driver pushes expected responses computed by a
// bit-stream reference model; a monitor pops and compares every cycle.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int EW      = CNT_W + 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               en = 1'b0;
  logic               in = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pat = '0;
  logic [LEN_W-1:0]   len = '0;
  logic               overlap = 1'b0;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
  logic               cfg_err;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .cfg_load (cfg_load),
    .pat      (pat),
    .len      (len),
    .overlap  (overlap),
    .out      (out),
    .match_cnt(match_cnt),
    .cnt_sat  (cnt_sat),
    .cfg_err  (cfg_err)
  );

  // ---------------- reference model ----------------
  // The model keeps the list of bits received since the last restart and
  // checks whether its tail spells the pattern (first bit = pat[len-1]).
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 stream[$];
  int                 m_cnt;

  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void model_reset();
    m_pat = 8'b0001_1011;
    m_len = 5;
    m_ovl = 1'b0;
    stream.delete();
    m_cnt = 0;
  endfunction

  function automatic logic [EW-1:0] pack(bit o, int c, bit e);
    logic [CNT_W-1:0] cv;
    cv = CNT_W'(c);
    return {o, cv, (c == CNT_MAX), e};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(bit e, bit b, bit ld, logic [MAX_LEN-1:0] p, int l, bit ov);
    bit o = 1'b0;
    bit er = 1'b0;
    bit hit;
    @(negedge clk);
    en = e; in = b; cfg_load = ld; pat = p; len = LEN_W'(l); overlap = ov;
    if (ld && l >= 1 && l <= MAX_LEN) begin
      m_pat = p; m_len = l; m_ovl = ov;
      stream.delete();
      m_cnt = 0;
    end else begin
      er = ld;
      if (e) begin
        stream.push_back(b);
        hit = (stream.size() >= m_len);
        if (hit) begin
          for (int k = 0; k < m_len; k++) begin
            if (stream[stream.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
          end
        end
        if (hit) begin
          o = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ovl) stream.delete();
        end
        while (stream.size() > MAX_LEN) void'(stream.pop_front());
      end
    end
    exp_q.push_back(pack(o, m_cnt, er));
  endtask

  task automatic cfg(logic [MAX_LEN-1:0] p, int l, bit ov);
    step(1'b0, 1'b0, 1'b1, p, l, ov);
  endtask

  // Send a string of '0'/'1' chars, inserting `gap` en-low cycles after each bit.
  task automatic send(string s, int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i] == "1", 1'b0, '0, 0, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (out !== 1'b0 || match_cnt !== '0 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: out=%b cnt=%0d err=%b, expected all zero", out, match_cnt, cfg_err);
    end
    exp_q.push_back(pack(1'b0, 0, 1'b0));
    @(negedge clk);
    rst = 1'b0; en = 1'b0; cfg_load = 1'b0;
    exp_q.push_back(pack(1'b0, 0, 1'b0));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_got;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {out, match_cnt, cnt_sat, cfg_err};
        vectors++;
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t: got out=%b cnt=%0d sat=%b err=%b, expected out=%b cnt=%0d sat=%b err=%b",
                   $time, mon_got[EW-1], mon_got[EW-2:2], mon_got[1], mon_got[0],
                   mon_exp[EW-1], mon_exp[EW-2:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Defaults, non-overlapping 11011.
    send("11011011", 0);
    // Overlapping 11011.
    cfg(8'b0001_1011, 5, 1'b1);
    send("11011011", 0);
    // Prefix fallback with defaults.
    cfg(8'b0001_1011, 5, 1'b0);
    send("111011", 0);
    // 101 with en gaps.
    cfg(8'b0000_0101, 3, 1'b0);
    send("101", 2);
    // Counter saturation with single-bit pattern.
    cfg(8'b0000_0001, 1, 1'b1);
    send("111111", 0);
    // Illegal loads leave detection of 11011 untouched.
    cfg(8'b0001_1011, 5, 1'b0);
    send("11", 0);
    step(1'b1, 1'b0, 1'b1, 8'hff, 0, 1'b1);
    send("1", 0);
    step(1'b1, 1'b1, 1'b1, 8'h00, 9, 1'b1);
    send("11011", 0);
    // Reset mid-sequence, then a lone 1 must not complete a match.
    send("1101", 0);
    do_reset();
    send("1", 0);
    send("1011", 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 63) == 0) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             MAX_LEN'($urandom), (($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(1, 4)),
             1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
             MAX_LEN'($urandom), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
      end
    end

    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-sequence detector with a registered Mealy-style match output. The pattern, its length and the overlap mode are programmable at run time. It also keeps a saturating match counter. It replaces the fixed-pattern single-mode detectors in the FSM library. Reset defaults reproduce the 11011 non-overlapping detector, so it drops in without configuration.

## Interface
- MAX_LEN, 8, longest supported pattern in bits (≥2)
- CNT_W, 16, match counter width
- DEF_PAT, 8'b0001_1011, pattern loaded at reset (MAX_LEN bits)
- DEF_LEN, 5, pattern length loaded at reset
- DEF_OVL, 0, overlap mode at reset
- Reset is rst: asynchronous, active-high. Clock is clk.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  qualifies in; bit consumed only when en=1
- in  in  1  serial data bit
- cfg_load  in  1  capture pat/len/overlap this cycle
- pat  in  MAX_LEN  pattern; pat[len-1] is the first bit received, pat[0] the last
- len  in  $clog2(MAX_LEN+1)  pattern length, legal 1..MAX_LEN
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- out  out  1  one-cycle match pulse, registered
- match_cnt  out  CNT_W  number of matches since reset or last accepted cfg_load, saturating
- cnt_sat  out  1  high while match_cnt is at all-ones
- cfg_err  out  1  one-cycle pulse: cfg_load rejected because len is illegal

## Operation
- State registers:
  - cfg_pat, cfg_len, cfg_ovl
  - hist, MAX_LEN-bit shift history with the newest bit at LSB
  - fill, 0..MAX_LEN saturating count of bits since the last restart
  - out, match_cnt, cfg_err
- Reset:
  - cfg registers take DEF_*.
  - hist=0, fill=0, out=0, match_cnt=0, cfg_err=0.
- Window: nxt = {hist[MAX_LEN-2:0], in}.
- match = en & (fill+1 ≥ cfg_len) & (nxt[cfg_len-1:0] == cfg_pat[cfg_len-1:0]). Implement this as a mask compare; bits above cfg_len are don't-care.
- When en=1:
  - hist <= nxt.
  - fill <= min(fill+1, MAX_LEN).
  - out <= match.
  - If match and cfg_ovl=0, fill <= 0. The next match needs cfg_len fresh bits.
  - A partial-prefix fallback inside one attempt is handled by the history, so 111011 matches for pattern 11011.
- When en=0: out <= 0. hist, fill and counter hold, so gaps in en are transparent.
- When match: match_cnt <= match_cnt+1, unless it is already all-ones.
- cfg_load with legal len:
  - Capture pat/len/overlap.
  - hist <= 0, fill <= 0, out <= 0, match_cnt <= 0.
  - The in bit on that cycle is discarded.
- cfg_load with len=0 or len>MAX_LEN: config and state are unchanged, cfg_err <= 1 for one cycle, and detection continues normally.
- cfg_load has priority over en in the same cycle.

## Timing
- Latency: out rises on the clock edge that samples the final pattern bit and is high for exactly that one cycle.
- Back-to-back matches in overlap mode give out high on consecutive cycles when the pattern allows it, e.g. all-ones.
- cnt_sat is combinational from match_cnt. match_cnt updates on the same edge as out.
- cfg_err is registered and appears one cycle after the cfg_load edge.
- Reset asserted mid-stream: all outputs go low immediately. A partial sequence in progress never matches after release.

## Structure
- Package seq_det_pkg holds the LEN_W localparam function ($clog2(MAX_LEN+1)) and the default pattern constants.
- Sub-module sat_counter (parameter W) with inputs inc and clr, outputs count and sat. It is reusable by other FSM blocks.
- Everything else is one always block for config, history and fill, plus a combinational mask/compare.

## Test plan
- Defaults, overlap=0, stream 1,1,0,1,1,0,1,1 -> out pulses only after bit 5. match_cnt=1.
- cfg_load pat=11011 len=5 overlap=1, same stream -> out after bits 5 and 8. match_cnt=2.
- Defaults, stream 1,1,1,0,1,1 -> out after bit 6 (prefix fallback).
- len=3 pat=101, en low for 2 cycles between every bit of 1,0,1 -> exactly one out pulse. out is never high while en=0.
- CNT_W=2, overlap=1, len=1 pat=1, six 1s -> match_cnt 1,2,3,3,3,3. cnt_sat high from the third match.
- cfg_load len=0 -> cfg_err pulse, detection of 11011 unchanged. rst asserted after 1,1,0,1, then 1 after release -> no out.
